// File: rtl/instr_encoder.sv
// Re-encodes a decoded control bundle into a 32-bit MIPS instruction word and writes it to
// instruction memory over a valid/ready port. Optional unmappable-bundle trap: `define ENC_ERR_CHECK_EN.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegDst,
    input  logic              Jump,
    input  logic              Branch,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemToReg,
    input  logic              ALUSrc,
    input  logic              RegWrite,
    input  logic [2:0]        ALUOp,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_load_val,
    output logic              im_wr_valid,
    input  logic              im_wr_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              enc_err,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {IDLE, ENCODE, WRITE} stateT;

    typedef struct packed {
        logic        regDst;
        logic        jump;
        logic        branch;
        logic        memRead;
        logic        memWrite;
        logic        memToReg;
        logic        aluSrc;
        logic        regWrite;
        logic [2:0]  aluOp;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } bundleT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    stateT       state;
    stateT       nextState;
    bundleT      inBundle;
    bundleT      cap;
    logic [5:0]  opcode;
    logic [25:0] operand;
    logic [15:0] wrCount;
    logic [5:0]  encOp;
    logic [25:0] encBody;
    logic        iType;
    logic        mappable;

    assign inBundle = '{regDst: RegDst, jump: Jump, branch: Branch, memRead: MemRead,
                        memWrite: MemWrite, memToReg: MemToReg, aluSrc: ALUSrc,
                        regWrite: RegWrite, aluOp: ALUOp, rs: rs, rt: rt, rd: rd,
                        shamt: shamt, funct: funct, imm: imm, target: target};

    assign in_ready    = (state == IDLE) && reset_n;
    assign im_wr_valid = (state == WRITE);
    assign im_wdata    = {opcode, operand};
    assign wr_count    = wrCount;

    // Opcode priority chain; an unmappable bundle leaves opcode and operand at zero.
    always_comb begin
        encOp    = OP_RTYPE;
        encBody  = '0;
        iType    = 1'b0;
        mappable = 1'b1;
        if (cap.jump) begin
            encOp   = OP_J;
            encBody = cap.target;
        end else if (cap.branch && cap.aluOp == 3'b000) begin
            encOp = OP_BEQ;
            iType = 1'b1;
        end else if (cap.aluOp == 3'b111 && cap.regDst && !cap.aluSrc) begin
            encOp   = OP_RTYPE;
            encBody = {cap.rs, cap.rt, cap.rd, cap.shamt, cap.funct};
        end else if (cap.aluSrc && cap.aluOp == 3'b101) begin
            encOp = OP_ADDI;
            iType = 1'b1;
        end else if (cap.aluSrc && cap.aluOp == 3'b100) begin
            encOp = OP_SLTI;
            iType = 1'b1;
        end else if (cap.aluSrc && cap.aluOp == 3'b011) begin
            encOp = OP_ANDI;
            iType = 1'b1;
        end else if (cap.aluSrc && cap.aluOp == 3'b010) begin
            encOp = OP_ORI;
            iType = 1'b1;
        end else if (cap.aluOp == 3'b001 && cap.memWrite) begin
            encOp = OP_SW;
            iType = 1'b1;
        end else if (cap.aluOp == 3'b001 && cap.memRead && cap.memToReg) begin
            encOp = OP_LW;
            iType = 1'b1;
        end else begin
            mappable = 1'b0;
        end
        if (iType) encBody = {cap.rs, cap.rt, cap.imm};
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (in_valid) nextState = ENCODE;
`ifdef ENC_ERR_CHECK_EN
            ENCODE:  nextState = mappable ? WRITE : IDLE;
`else
            ENCODE:  nextState = WRITE;
`endif
            WRITE:   if (im_wr_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cap     <= '0;
            opcode  <= '0;
            operand <= '0;
            im_addr <= '0;
            wrCount <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (in_valid)  cap     <= inBundle;
                    if (addr_load) im_addr <= addr_load_val;
                end
                ENCODE: begin
                    opcode  <= encOp;
                    operand <= encBody;
                end
                WRITE: begin
                    if (im_wr_ready) begin
                        im_addr <= im_addr + ADDR_W'(1);
                        wrCount <= wrCount + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ENC_ERR_CHECK_EN
    logic encErr;

    always_ff @(posedge clk) begin
        if (!reset_n) encErr <= 1'b0;
        else          encErr <= (state == ENCODE) && !mappable;
    end

    assign enc_err = encErr;
`else
    assign enc_err = 1'b0;
`endif

    // RegWrite has no bearing on the encoding; it is captured but otherwise unused.
    logic unusedBits;
    assign unusedBits = ^{cap.regWrite, mappable};

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected writes are queued at issue time and
// popped by a monitor on each completed memory handshake.
module tb_instr_encoder;

    localparam int ADDR_W = 8;

    typedef struct packed {
        logic        RegDst;
        logic        Jump;
        logic        Branch;
        logic        MemRead;
        logic        MemWrite;
        logic        MemToReg;
        logic        ALUSrc;
        logic        RegWrite;
        logic [2:0]  ALUOp;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } bundleT;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } writeT;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              RegDst = 1'b0, Jump = 1'b0, Branch = 1'b0, MemRead = 1'b0;
    logic              MemWrite = 1'b0, MemToReg = 1'b0, ALUSrc = 1'b0, RegWrite = 1'b0;
    logic [2:0]        ALUOp = '0;
    logic [4:0]        rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]        funct = '0;
    logic [15:0]       imm = '0;
    logic [25:0]       target = '0;
    logic              addr_load = 1'b0;
    logic [ADDR_W-1:0] addr_load_val = '0;
    logic              im_wr_valid;
    logic              im_wr_ready = 1'b1;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              enc_err;
    logic [15:0]       wr_count;

    int    checks = 0;
    int    errors = 0;
    writeT sbQ[$];
    logic [ADDR_W-1:0] expAddr = '0;
    logic [15:0]       expCount = '0;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .RegDst(RegDst), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .ALUOp(ALUOp), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .addr_load(addr_load), .addr_load_val(addr_load_val),
        .im_wr_valid(im_wr_valid), .im_wr_ready(im_wr_ready), .im_addr(im_addr),
        .im_wdata(im_wdata), .enc_err(enc_err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && im_wr_valid && im_wr_ready) begin
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", im_addr, im_wdata);
            end else begin
                writeT exp;
                exp = sbQ.pop_front();
                if (im_addr !== exp.addr || im_wdata !== exp.data) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                             im_addr, im_wdata, exp.addr, exp.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input bundleT b);
        {RegDst, Jump, Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite} =
            {b.RegDst, b.Jump, b.Branch, b.MemRead, b.MemWrite, b.MemToReg, b.ALUSrc, b.RegWrite};
        ALUOp = b.ALUOp; rs = b.rs; rt = b.rt; rd = b.rd; shamt = b.shamt;
        funct = b.funct; imm = b.imm; target = b.target;
    endtask

    // Waits (bounded) for in_ready, then presents the bundle for one accepted cycle.
    task automatic send(input bundleT b, input logic doLoad, input logic [ADDR_W-1:0] loadVal,
                        output int waited);
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b want 1", in_ready);
        end
        apply(b);
        in_valid = 1'b1;
        addr_load = doLoad;
        addr_load_val = loadVal;
        tick();
        in_valid = 1'b0;
        addr_load = 1'b0;
    endtask

    task automatic expect_write(input logic [31:0] word);
        sbQ.push_back('{addr: expAddr, data: word});
        expAddr  = expAddr + 8'd1;
        expCount = expCount + 16'd1;
    endtask

    task automatic drain();
        int n = 0;
        while (!(sbQ.size() == 0 && in_ready) && n < 30) begin
            tick();
            n++;
        end
        if (sbQ.size() != 0 || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d want 0", sbQ.size());
        end
    endtask

    task automatic load_addr(input logic [ADDR_W-1:0] a);
        addr_load = 1'b1;
        addr_load_val = a;
        tick();
        addr_load = 1'b0;
        expAddr = a;
    endtask

    function automatic bundleT rtype_bundle();
        bundleT b = '0;
        b.RegDst = 1'b1; b.ALUOp = 3'b111; b.RegWrite = 1'b1;
        b.rs = 5'd1; b.rt = 5'd2; b.rd = 5'd3; b.shamt = 5'd0; b.funct = 6'h20;
        return b;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got %b want 0", in_ready); end
        reset_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, im_wr_valid, enc_err, im_addr, im_wdata, wr_count} !== {3'b100, 8'h00, 32'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b val=%b err=%b addr=%h data=%h cnt=%h want 1 0 0 00 0 0",
                     in_ready, im_wr_valid, enc_err, im_addr, im_wdata, wr_count);
        end
        expAddr = '0;
        expCount = '0;
    endtask

    task automatic test_rtype();
        int w;
        expect_write(32'h00221820);
        send(rtype_bundle(), 1'b0, '0, w);
        drain();
        checks++;
        if (wr_count !== 16'd1 || im_addr !== 8'h01) begin
            errors++;
            $display("FAIL rtype_count got cnt=%0d addr=%h want 1 01", wr_count, im_addr);
        end
    endtask

    task automatic test_stall();
        bundleT b = '0;
        int w;
        b.ALUSrc = 1'b1; b.RegWrite = 1'b1; b.ALUOp = 3'b101; b.rt = 5'd5; b.imm = 16'hFFFF;
        im_wr_ready = 1'b0;
        load_addr(8'h10);
        expect_write(32'h2005FFFF);
        send(b, 1'b0, '0, w);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (im_wr_valid !== 1'b1 || im_addr !== 8'h10 || im_wdata !== 32'h2005FFFF) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got val=%b addr=%h data=%h want 1 10 2005ffff",
                         i, im_wr_valid, im_addr, im_wdata);
            end
            tick();
        end
        im_wr_ready = 1'b1;
        drain();
        checks++;
        if (im_addr !== 8'h11) begin errors++; $display("FAIL stall_addr_after got %h want 11", im_addr); end
    endtask

    task automatic test_jump_priority();
        bundleT b = '0;
        int w;
        b.Jump = 1'b1; b.ALUOp = 3'b101; b.ALUSrc = 1'b1; b.Branch = 1'b1; b.target = 26'h0000040;
        expect_write(32'h08000040);
        send(b, 1'b0, '0, w);
        drain();
        checks++;
        if (wr_count !== expCount) begin errors++; $display("FAIL jump_count got %0d want %0d", wr_count, expCount); end
    endtask

    task automatic test_wrap();
        bundleT b = '0;
        int w;
        b.ALUOp = 3'b001; b.MemWrite = 1'b1; b.ALUSrc = 1'b1; b.rs = 5'd29; b.rt = 5'd31; b.imm = 16'h0004;
        load_addr(8'hFF);
        expect_write(32'hAFBF0004);
        send(b, 1'b0, '0, w);
        drain();
        checks++;
        if (im_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr got %h want 00", im_addr); end
    endtask

    task automatic test_load_with_valid();
        int w;
        expAddr = 8'h40;
        expect_write(32'h00221820);
        send(rtype_bundle(), 1'b1, 8'h40, w);
        drain();
        checks++;
        if (im_addr !== 8'h41) begin errors++; $display("FAIL load_with_valid_addr got %h want 41", im_addr); end
    endtask

    task automatic test_back_to_back();
        bundleT tbl[6];
        logic [31:0] expW[6];
        int w;
        foreach (tbl[i]) tbl[i] = '0;
        tbl[0].Branch = 1'b1; tbl[0].rs = 5'd3; tbl[0].rt = 5'd4; tbl[0].imm = 16'h0010;
        expW[0] = 32'h10640010;
        tbl[1].ALUOp = 3'b001; tbl[1].MemRead = 1'b1; tbl[1].MemToReg = 1'b1; tbl[1].ALUSrc = 1'b1;
        tbl[1].rs = 5'd2; tbl[1].rt = 5'd7; tbl[1].imm = 16'h0008;
        expW[1] = 32'h8C470008;
        tbl[2].ALUOp = 3'b100; tbl[2].ALUSrc = 1'b1; tbl[2].rs = 5'd1; tbl[2].rt = 5'd2; tbl[2].imm = 16'h1234;
        expW[2] = 32'h28221234;
        tbl[3].ALUOp = 3'b011; tbl[3].ALUSrc = 1'b1; tbl[3].rs = 5'd31; tbl[3].imm = 16'hABCD;
        expW[3] = 32'h33E0ABCD;
        tbl[4].ALUOp = 3'b010; tbl[4].ALUSrc = 1'b1; tbl[4].rt = 5'd31; tbl[4].imm = 16'h0F0F;
        expW[4] = 32'h341F0F0F;
        tbl[5].Branch = 1'b1; tbl[5].ALUOp = 3'b001; tbl[5].MemWrite = 1'b1; tbl[5].ALUSrc = 1'b1;
        tbl[5].rs = 5'd5; tbl[5].rt = 5'd6; tbl[5].imm = 16'h0020;
        expW[5] = 32'hACA60020;
        for (int i = 0; i < 6; i++) begin
            expect_write(expW[i]);
            send(tbl[i], 1'b0, '0, w);
            if (i > 0) begin
                checks++;
                if (w !== 2) begin errors++; $display("FAIL b2b_interval item %0d got %0d want 2", i, w); end
            end
        end
        drain();
        checks++;
        if (wr_count !== expCount || im_addr !== expAddr) begin
            errors++;
            $display("FAIL b2b_totals got cnt=%0d addr=%h want %0d %h", wr_count, im_addr, expCount, expAddr);
        end
    endtask

    task automatic test_unmappable();
        bundleT b = '0;
        int w;
        b.ALUOp = 3'b110; b.ALUSrc = 1'b1; b.RegDst = 1'b1; b.rs = 5'd9; b.rt = 5'd10; b.imm = 16'h5555;
`ifdef ENC_ERR_CHECK_EN
        send(b, 1'b0, '0, w);
        tick();
        checks++;
        if (enc_err !== 1'b1 || im_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL unmap_pulse got err=%b val=%b want 1 0", enc_err, im_wr_valid);
        end
        tick();
        checks++;
        if (enc_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL unmap_after got err=%b rdy=%b want 0 1", enc_err, in_ready);
        end
`else
        expect_write(32'h00000000);
        send(b, 1'b0, '0, w);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (enc_err !== 1'b0) begin errors++; $display("FAIL unmap_err_tied got %b want 0", enc_err); end
            tick();
        end
        drain();
`endif
        checks++;
        if (wr_count !== expCount || im_addr !== expAddr) begin
            errors++;
            $display("FAIL unmap_totals got cnt=%0d addr=%h want %0d %h", wr_count, im_addr, expCount, expAddr);
        end
    endtask

    task automatic test_reset_mid_write();
        int w;
        im_wr_ready = 1'b0;
        send(rtype_bundle(), 1'b0, '0, w);
        tick();
        checks++;
        if (im_wr_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid got %b want 1", im_wr_valid); end
        reset_n = 1'b0;
        tick();
        checks++;
        if (im_wr_valid !== 1'b0 || wr_count !== 16'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abandon got val=%b cnt=%0d rdy=%b want 0 0 0", im_wr_valid, wr_count, in_ready);
        end
        reset_n = 1'b1;
        im_wr_ready = 1'b1;
        expAddr = '0;
        expCount = '0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || im_addr !== 8'h00) begin
            errors++;
            $display("FAIL midreset_ready got rdy=%b addr=%h want 1 00", in_ready, im_addr);
        end
        expect_write(32'h00221820);
        send(rtype_bundle(), 1'b0, '0, w);
        drain();
        checks++;
        if (wr_count !== 16'd1) begin errors++; $display("FAIL midreset_recount got %0d want 1", wr_count); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_stall();
        test_jump_priority();
        test_wrap();
        test_load_with_valid();
        test_back_to_back();
        test_unmappable();
        test_reset_mid_write();
        tick();
        checks++;
        if (sbQ.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sbQ.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
